// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and response record for the 16-bit ALU sequencer.
package alu_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] result;
    logic                 carry;
    logic                 ovf;
    logic                 zero;
    logic                 err;
  } rsp_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester and alu_op_sequencer.
interface alu_op_sequencer_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_err
  );
endinterface

// File: rtl/add_16_cin.sv
// Ripple-carry adder with carry-in/out, one full-adder cell per bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_16_cin #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;
  assign cout = c[WIDTH];

  full_adder u_fa [WIDTH-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[WIDTH-1:0]),
    .s  (sum),
    .co (c[WIDTH:1])
  );
endmodule

// File: rtl/alu_op_sequencer.sv
// Single-transaction ALU control stage driving a shared ripple adder.
// Shift-add multiply is built only when ALU_OP_SEQUENCER_MUL_EN is defined.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MUL_STEPS = WIDTH
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  if (WIDTH != 16 || MUL_STEPS < 1) begin : g_bad_cfg
    $error("alu_op_sequencer: unsupported WIDTH/MUL_STEPS");
  end

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  rsp_t             rsp_q, rsp_exec;

  logic [WIDTH-1:0] add_x, add_y, add_s;
  logic             add_ci, add_co;

`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  logic [WIDTH-1:0] hi_q, lo_q, hi_nx, lo_nx, ms;
  logic [CNT_W-1:0] cnt_q;
  logic             mc;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) begin
`ifdef ALU_OP_SEQUENCER_MUL_EN
        state_d = (op_e'(bus.in_op) == OP_MUL) ? ST_MUL : ST_EXEC;
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: state_d = ST_DONE;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      ST_MUL:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
`endif
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- shared adder ----------------
  always_comb begin
    add_x  = a_q;
    add_y  = b_q;
    add_ci = 1'b0;
    if (op_q == OP_SUB) begin
      add_y  = ~b_q;
      add_ci = 1'b1;
    end
`ifdef ALU_OP_SEQUENCER_MUL_EN
    if (state_q == ST_MUL) begin
      add_x  = hi_q;
      add_y  = a_q;
      add_ci = 1'b0;
    end
`endif
  end

  add_16_cin #(.WIDTH(WIDTH)) u_add (
    .a    (add_x),
    .b    (add_y),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co)
  );

  // ---------------- single-cycle ops ----------------
  always_comb begin
    rsp_exec = '0;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        rsp_exec.result = add_s;
        rsp_exec.carry  = add_co;
        // add_y is the adder's real second operand, so SUB overflow falls out too
        rsp_exec.ovf    = (a_q[WIDTH-1] == add_y[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  rsp_exec.result = a_q & b_q;
      OP_OR:   rsp_exec.result = a_q | b_q;
      OP_XOR:  rsp_exec.result = a_q ^ b_q;
      OP_NOT:  rsp_exec.result = ~a_q;
      default: rsp_exec.err    = 1'b1;
    endcase
    rsp_exec.zero = (rsp_exec.result == '0);
  end

`ifdef ALU_OP_SEQUENCER_MUL_EN
  // one shift-add step: {c,hi,lo} >> 1 after the conditional add
  always_comb begin
    mc    = lo_q[0] ? add_co : 1'b0;
    ms    = lo_q[0] ? add_s  : hi_q;
    hi_nx = {mc, ms[WIDTH-1:1]};
    lo_nx = {ms[0], lo_q[WIDTH-1:1]};
  end
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      rsp_q <= '0;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          op_q  <= op_e'(bus.in_op);
          a_q   <= bus.in_a;
          b_q   <= bus.in_b;
`ifdef ALU_OP_SEQUENCER_MUL_EN
          hi_q  <= '0;
          lo_q  <= bus.in_b;
          cnt_q <= '0;
`endif
        end
        ST_EXEC: rsp_q <= rsp_exec;
`ifdef ALU_OP_SEQUENCER_MUL_EN
        ST_MUL: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST)
            rsp_q <= '{result: lo_nx, carry: |hi_nx, ovf: 1'b0,
                       zero: (lo_nx == '0), err: 1'b0};
        end
`endif
        ST_DONE: if (bus.out_ready) begin
          // flags drop with out_valid; the result word is left in place
          rsp_q.carry <= 1'b0;
          rsp_q.ovf   <= 1'b0;
          rsp_q.zero  <= 1'b0;
          rsp_q.err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = rsp_q.result;
  assign bus.out_carry  = rsp_q.carry;
  assign bus.out_ovf    = rsp_q.ovf;
  assign bus.out_zero   = rsp_q.zero;
  assign bus.out_err    = rsp_q.err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer; honours ALU_OP_SEQUENCER_MUL_EN.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] r;
    logic        c, v, z, e;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        x;
    logic [16:0] s;
    logic [31:0] p;
    x = '{r: 16'h0, c: 1'b0, v: 1'b0, z: 1'b0, e: 1'b0, lat: 1};
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        x.r = s[15:0]; x.c = s[16];
        x.v = (a[15] == b[15]) && (x.r[15] != a[15]);
      end
      3'd1: begin
        x.r = a - b; x.c = (a >= b);
        x.v = (a[15] != b[15]) && (x.r[15] != a[15]);
      end
      3'd2: x.r = a & b;
      3'd3: x.r = a | b;
      3'd4: x.r = a ^ b;
      3'd5: x.r = ~a;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      3'd6: begin
        p = 32'(a) * 32'(b);
        x.r = p[15:0]; x.c = (p[31:16] != 16'h0); x.lat = 16;
      end
`endif
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 16'h0);
    return x;
  endfunction

  // drive one request, wait for its result, optionally stall the consumer
  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int hold);
    exp_t x;
    int   lat;
    logic [15:0] r0;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    if (!bus.out_valid) begin
      chk({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, ".lat"},    32'(lat),        32'(x.lat));
    chk({tag, ".result"}, 32'(bus.out_result), 32'(x.r));
    chk({tag, ".flags"},  {28'd0, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_err},
                          {28'd0, x.c, x.v, x.z, x.e});
    r0 = bus.out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold"}, {bus.out_valid, bus.in_ready, bus.out_result, bus.out_carry,
                           bus.out_ovf, bus.out_zero, bus.out_err},
                          {1'b1, 1'b0, x.r, x.c, x.v, x.z, x.e});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".release"}, {bus.out_valid, bus.in_ready, bus.out_result, bus.out_zero, bus.out_err},
                           {1'b0, 1'b1, r0, 1'b0, 1'b0});
  endtask

  initial begin
    int vseen;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = 16'h0; bus.in_b = 16'h0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset", {bus.in_ready, bus.out_valid, bus.out_result, bus.out_carry,
                  bus.out_ovf, bus.out_zero, bus.out_err}, {1'b1, 1'b0, 16'h0, 4'h0});
    @(negedge clk); rst = 1'b0;

    do_op("add",     3'd0, 16'd756,  16'd3080, 0);
    do_op("sub_neg", 3'd1, 16'd5,    16'd7,    0);
    do_op("sub_ovf", 3'd1, 16'h8000, 16'h0001, 0);
    do_op("sub_wrap",3'd1, 16'h0000, 16'h0001, 0);
    do_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 0);
    do_op("add_cry", 3'd0, 16'hFFFF, 16'h0001, 0);
    do_op("and",     3'd2, 16'h00F0, 16'h0FF0, 0);
    do_op("or",      3'd3, 16'h00F0, 16'h0FF0, 0);
    do_op("xor",     3'd4, 16'h00F0, 16'h0FF0, 0);
    do_op("not",     3'd5, 16'h00F0, 16'h0FF0, 0);
    do_op("rsvd",    3'd7, 16'hFFFF, 16'hFFFF, 0);
    do_op("mul",     3'd6, 16'd300,  16'd200,  0);
    do_op("mul_hi",  3'd6, 16'h0100, 16'h0100, 0);
    do_op("mul_ff",  3'd6, 16'hFFFF, 16'hFFFF, 0);
    do_op("bp_add",  3'd0, 16'h1234, 16'h4321, 10);
    for (int i = 0; i < 8; i++)
      do_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), i % 3);

    // reset in the middle of a multiply, off the clock edge
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd6; bus.in_a = 16'd300; bus.in_b = 16'd200;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid", {bus.in_ready, bus.out_valid, bus.out_result, bus.out_carry,
                    bus.out_ovf, bus.out_zero, bus.out_err}, {1'b1, 1'b0, 16'h0, 4'h0});
    #3 rst = 1'b0;
    vseen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) vseen++;
    end
    chk("rst_no_out", 32'(vseen), 32'd0);
    do_op("post_rst", 3'd0, 16'd1, 16'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
